nvram_upload_reader: RTL

- Serves HPS upload requests (core -> HPS) from a core-side RAM region such as hiscore or NVRAM.
- Complements the ROM download write path into the arcade core.
- Sits between hps_io's ioctl upload signals and a read port of a core dual-port RAM.
- Pauses the game core for the duration of an upload so RAM contents stay coherent.

---
 rtl/nvram_upload_reader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader
//
// Serves HPS upload requests (core -> HPS) from a core-side RAM region such
// as hiscore or NVRAM storage. It sits between the hps_io ioctl upload
// signals and one read port of a core dual-port RAM. While an upload is in
// progress the game core is paused so the RAM contents stay coherent.
//
// Parameters:
//   ADDR_W - RAM address width; the region is 2**ADDR_W bytes
//   RD_LAT - RAM read latency in clocks from ram_rd to valid ram_q (1..3)
//   FILL   - byte returned for requests outside the region
//
// Ports:
//   CLK, RESET    - system clock, asynchronous active-high reset
//   ioctl_upload  - high for the whole upload transfer
//   ioctl_rd      - one-cycle byte request strobe
//   ioctl_addr    - byte address of the request, valid with ioctl_rd
//   ioctl_din     - returned byte, valid while ioctl_wait is low after a request
//   ioctl_wait    - stalls the HPS while high
//   pause_req     - asks the game core to halt
//   pause_ack     - game core reports it is halted
//   ram_addr      - RAM read address
//   ram_rd        - one-cycle RAM read strobe
//   ram_q         - RAM read data
//   busy          - high whenever the reader is not idle
//   byte_count    - completed reads since the upload started, saturating
module nvram_upload_reader #(
    parameter int         ADDR_W = 10,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] FILL   = 8'hFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              busy,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAUSE   = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_FETCH   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [1:0]      LAT_LAST = 2'(RD_LAT);
    localparam logic [ADDR_W:0] CNT_MAX  = '1;

    logic [2:0]        state_q,     state_d;
    logic              uploadPrev_q;
    logic [7:0]        din_q,       din_d;
    logic              wait_q,      wait_d;
    logic              pauseReq_q,  pauseReq_d;
    logic [ADDR_W-1:0] ramAddr_q,   ramAddr_d;
    logic              ramRd_q,     ramRd_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [1:0]        latCnt_q,    latCnt_d;

    logic              uploadRise;
    logic              inRange;
    logic [ADDR_W:0]   countInc;

    // The registered copy resets to 0, so an upload already high when reset
    // is released is still seen as a fresh rising edge.
    assign uploadRise = ioctl_upload & ~uploadPrev_q;

    // Any address bit at or above ADDR_W puts the request outside the region.
    assign inRange = ((ioctl_addr >> ADDR_W) == 25'd0);

    assign countInc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

    // Next-state logic. ram_rd defaults low so it can only ever be a single
    // cycle pulse. A low ioctl_upload is checked before ioctl_rd so an upload
    // ending in the same cycle as a request drops that request.
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        wait_d     = wait_q;
        pauseReq_d = pauseReq_q;
        ramAddr_d  = ramAddr_q;
        ramRd_d    = 1'b0;
        count_d    = count_q;
        latCnt_d   = latCnt_q;

        case (state_q)
            S_IDLE: begin
                if (uploadRise) begin
                    state_d    = S_PAUSE;
                    pauseReq_d = 1'b1;
                    wait_d     = 1'b1;
                    count_d    = '0;
                end
            end

            S_PAUSE: begin
                if (!ioctl_upload) begin
                    state_d    = S_RELEASE;
                    pauseReq_d = 1'b0;
                    wait_d     = 1'b0;
                end else if (pause_ack) begin
                    state_d = S_READY;
                    wait_d  = 1'b0;
                end
            end

            S_READY: begin
                if (!ioctl_upload) begin
                    state_d    = S_RELEASE;
                    pauseReq_d = 1'b0;
                    wait_d     = 1'b0;
                end else if (ioctl_rd) begin
                    if (inRange) begin
                        state_d   = S_FETCH;
                        ramAddr_d = ioctl_addr[ADDR_W-1:0];
                        ramRd_d   = 1'b1;
                        wait_d    = 1'b1;
                        latCnt_d  = '0;
                    end else begin
                        din_d   = FILL;
                        count_d = countInc;
                    end
                end
            end

            // latCnt_q is 0 in the ram_rd cycle and reaches RD_LAT in the
            // cycle where ram_q is valid; that is where the byte is captured.
            S_FETCH: begin
                if (!ioctl_upload) begin
                    state_d    = S_RELEASE;
                    pauseReq_d = 1'b0;
                    wait_d     = 1'b0;
                end else if (latCnt_q == LAT_LAST) begin
                    state_d = S_READY;
                    din_d   = ram_q;
                    wait_d  = 1'b0;
                    count_d = countInc;
                end else begin
                    latCnt_d = latCnt_q + 2'd1;
                end
            end

            S_RELEASE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                pauseReq_d = 1'b0;
                wait_d     = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            uploadPrev_q <= 1'b0;
            din_q        <= '0;
            wait_q       <= 1'b0;
            pauseReq_q   <= 1'b0;
            ramAddr_q    <= '0;
            ramRd_q      <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
            latCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            uploadPrev_q <= ioctl_upload;
            din_q        <= din_d;
            wait_q       <= wait_d;
            pauseReq_q   <= pauseReq_d;
            ramAddr_q    <= ramAddr_d;
            ramRd_q      <= ramRd_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
            latCnt_q     <= latCnt_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign pause_req  = pauseReq_q;
    assign ram_addr   = ramAddr_q;
    assign ram_rd     = ramRd_q;
    assign busy       = busy_q;
    assign byte_count = count_q;

endmodule
